// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit feeding the HI/LO register sources.
// Signed multiply uses radix-2 Booth; unsigned multiply uses the same Booth
// datapath and adds a final correction in FIX. Division is restoring on operand
// magnitudes, with signs applied in FIX. Both share one iteration counter.
// Optional feature: define MDU_HILO_WRITE_EN to add hi_we/lo_we/wdata (mthi/mtlo).
// WIDTH must be >= 4 and 2**CNT_W must exceed WIDTH.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             op_q;
    logic             sgn_q;
    logic             qneg_q;    // quotient must be negated
    logic             rneg_q;    // remainder must be negated (dividend was negative)
    logic             q1_q;      // Booth q(-1) bit; holds a[WIDTH-1] after the last step
    // Mult: Booth partial product P with two guard bits. Div: remainder in [WIDTH:0].
    logic [WIDTH+1:0] acc_hi_q;
    // Mult: shifting multiplier / low product. Div: dividend shifting into quotient.
    logic [WIDTH-1:0] acc_lo_q;
    // Mult: multiplicand extended per signedness. Div: divisor magnitude.
    logic [WIDTH:0]   opnd_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH+1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] mul_hi_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes and signs for the divider, taken at the start edge.
    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One Booth step and one restoring-divide step, plus the FIX-cycle results.
    always_comb begin
        b_ext = {opnd_q[WIDTH], opnd_q};
        case ({acc_lo_q[0], q1_q})
            2'b01:   booth_sum = acc_hi_q + b_ext;
            2'b10:   booth_sum = acc_hi_q - b_ext;
            default: booth_sum = acc_hi_q;
        endcase
        mul_hi_nx = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
        mul_lo_nx = {booth_sum[0], acc_lo_q[WIDTH-1:1]};

        // Remainder stays below the divisor, so the trial difference fits WIDTH+1 bits.
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_trial = div_shift - opnd_q;
        if (!div_trial[WIDTH]) begin
            rem_nx = div_trial;
            quo_nx = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = div_shift;
            quo_nx = {acc_lo_q[WIDTH-2:0], 1'b0};
        end

        // Booth treats the multiplier as signed; for unsigned with MSB set add b<<WIDTH back.
        mul_hi_fix = acc_hi_q[WIDTH-1:0] + ((!sgn_q && q1_q) ? opnd_q[WIDTH-1:0] : '0);
        quo_fix    = qneg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix    = rneg_q ? (~acc_hi_q[WIDTH-1:0] + 1'b1) : acc_hi_q[WIDTH-1:0];
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= 1'b0;
            sgn_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            q1_q     <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef MDU_HILO_WRITE_EN
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
`endif
                    if (start) begin
                        if (op && (b == '0)) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state_q  <= StRun;
                            busy     <= 1'b1;
                            count_q  <= '0;
                            op_q     <= op;
                            sgn_q    <= is_signed;
                            q1_q     <= 1'b0;
                            acc_hi_q <= '0;
                            if (op) begin
                                acc_lo_q <= a_mag;
                                opnd_q   <= {1'b0, b_mag};
                                rneg_q   <= a_neg;
                                qneg_q   <= a_neg ^ b_neg;
                            end else begin
                                acc_lo_q <= a;
                                opnd_q   <= {is_signed & b[WIDTH-1], b};
                                rneg_q   <= 1'b0;
                                qneg_q   <= 1'b0;
                            end
                        end
                    end
                end
                StRun: begin
                    count_q <= count_q + 1'b1;
                    if (op_q) begin
                        acc_hi_q <= {1'b0, rem_nx};
                        acc_lo_q <= quo_nx;
                    end else begin
                        acc_hi_q <= mul_hi_nx;
                        acc_lo_q <= mul_lo_nx;
                        q1_q     <= acc_lo_q[0];
                    end
                    if (count_q == CNT_W'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (op_q) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= mul_hi_fix;
                        lo <= acc_lo_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
